wr_addr_decode: RTL and testbench

- Register-file write-address decoder: 5-bit address plus write-enable in, 32-bit one-hot write-select out.
- Built as a 2-to-4 pre-decoder (decoder2_4) on addr[4:3], which enables one of four 3-to-8 decoders (decoder3_8) on addr[2:0].
- Provides a combinational select and a registered copy of the select for the write port of the 32-entry register file.

---
 rtl/wr_addr_decode_pkg.sv | 6 +
 rtl/wr_addr_decode_if.sv | 13 +
 rtl/wr_addr_decode_decoder2_4.sv | 13 +
 rtl/wr_addr_decode_decoder3_8.sv | 13 +
 rtl/wr_addr_decode.sv | 41 ++++
 tb/tb_wr_addr_decode.sv | 199 +++++++++++++++++++
 6 files changed

// File: rtl/wr_addr_decode_pkg.sv
// rtl/wr_addr_decode_pkg.sv - shared sizes for the register-file write-address decoder
`timescale 1ps/1ps
package wr_addr_decode_pkg;
  localparam int N_REGS = 32;
  localparam int ADDR_W = 5;
endpackage

// File: rtl/wr_addr_decode_if.sv
// rtl/wr_addr_decode_if.sv - write-address bus: address/enable in, one-hot selects out
`timescale 1ps/1ps
interface wr_addr_decode_if;
  import wr_addr_decode_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic              en;
  logic [N_REGS-1:0] sel;
  logic [N_REGS-1:0] sel_q;

  modport master (output addr, output en, input sel, input sel_q);
  modport slave  (input addr, input en, output sel, output sel_q);
endinterface

// File: rtl/wr_addr_decode_decoder2_4.sv
// rtl/wr_addr_decode_decoder2_4.sv - enabled 2-to-4 decoder with per-output gate delay
`timescale 1ps/1ps
module decoder2_4 #(
  parameter int DELAY = 50
) (
  input  logic [1:0] in,
  input  logic       e,
  output logic [3:0] out
);
  for (genvar k = 0; k < 4; k++) begin : g_out
    assign #DELAY out[k] = e & (in == 2'(k));
  end
endmodule

// File: rtl/wr_addr_decode_decoder3_8.sv
// rtl/wr_addr_decode_decoder3_8.sv - enabled 3-to-8 decoder with per-output gate delay
`timescale 1ps/1ps
module decoder3_8 #(
  parameter int DELAY = 50
) (
  input  logic [2:0] in,
  input  logic       e,
  output logic [7:0] out
);
  for (genvar k = 0; k < 8; k++) begin : g_out
    assign #DELAY out[k] = e & (in == 3'(k));
  end
endmodule

// File: rtl/wr_addr_decode.sv
// rtl/wr_addr_decode.sv - 5-to-32 one-hot write select, combinational plus registered copy
`timescale 1ps/1ps
module wr_addr_decode
  import wr_addr_decode_pkg::*;
#(
  parameter int DELAY = 50
) (
  input  logic            clk,
  input  logic            rst_n,
  wr_addr_decode_if.slave bus
);
  logic [3:0]        grp;
  logic [N_REGS-1:0] sel_w;
  logic [N_REGS-1:0] sel_r;

  // addr[4:3] picks which bank of eight the low bits decode into
  decoder2_4 #(.DELAY(DELAY)) u_pre (
    .in  (bus.addr[4:3]),
    .e   (bus.en),
    .out (grp)
  );

  for (genvar j = 0; j < 4; j++) begin : g_bank
    decoder3_8 #(.DELAY(DELAY)) u_dec (
      .in  (bus.addr[2:0]),
      .e   (grp[j]),
      .out (sel_w[8*j +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r <= '0;
    end else begin
      sel_r <= sel_w;
    end
  end

  assign bus.sel   = sel_w;
  assign bus.sel_q = sel_r;
endmodule

// File: tb/tb_wr_addr_decode.sv
// tb/tb_wr_addr_decode.sv - directed self-checking bench for wr_addr_decode
`timescale 1ps/1ps
module tb_wr_addr_decode;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  wr_addr_decode_if bus ();

  wr_addr_decode #(.DELAY(50)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #500 clk = ~clk;

  task automatic test_reset();
    rst_n    = 1'b0;
    bus.en   = 1'b1;
    bus.addr = 5'd5;
    #110;
    n_checks++;
    if (bus.sel !== 32'h0000_0020) begin
      n_fail++;
      $display("FAIL reset_sel: got %h want %h", bus.sel, 32'h0000_0020);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.sel_q !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_sel_q[%0d]: got %h want %h", i, bus.sel_q, 32'h0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.sel_q !== 32'h0000_0020) begin
      n_fail++;
      $display("FAIL reset_release: got %h want %h", bus.sel_q, 32'h0000_0020);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] exp;
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      bus.en   = 1'b1;
      bus.addr = 5'(a);
      exp      = 32'h1 << a;
      #200;
      n_checks++;
      if (bus.sel !== exp) begin
        n_fail++;
        $display("FAIL sweep_sel addr=%0d: got %h want %h", a, bus.sel, exp);
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus.sel_q !== exp) begin
        n_fail++;
        $display("FAIL sweep_sel_q addr=%0d: got %h want %h", a, bus.sel_q, exp);
      end
    end
  endtask

  task automatic test_disable();
    logic [4:0] addrs [3];
    addrs = '{5'd0, 5'd17, 5'd31};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.en   = 1'b0;
      bus.addr = addrs[i];
      #200;
      n_checks++;
      if (bus.sel !== 32'h0) begin
        n_fail++;
        $display("FAIL disable_sel addr=%0d: got %h want %h", addrs[i], bus.sel, 32'h0);
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus.sel_q !== 32'h0) begin
        n_fail++;
        $display("FAIL disable_sel_q addr=%0d: got %h want %h", addrs[i], bus.sel_q, 32'h0);
      end
    end
    @(negedge clk);
    bus.en   = 1'b1;
    bus.addr = 5'd17;
    #200;
    n_checks++;
    if (bus.sel !== 32'h0002_0000) begin
      n_fail++;
      $display("FAIL reenable_sel: got %h want %h", bus.sel, 32'h0002_0000);
    end
  endtask

  task automatic test_group_boundaries();
    logic [4:0]  lo_a  [3];
    logic [31:0] lo_s  [3];
    logic [31:0] hi_s  [3];
    lo_a = '{5'd7, 5'd15, 5'd23};
    lo_s = '{32'h0000_0080, 32'h0000_8000, 32'h0080_0000};
    hi_s = '{32'h0000_0100, 32'h0001_0000, 32'h0100_0000};
    bus.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.addr = lo_a[i];
      #200;
      n_checks++;
      if (bus.sel !== lo_s[i]) begin
        n_fail++;
        $display("FAIL group_lo addr=%0d: got %h want %h", lo_a[i], bus.sel, lo_s[i]);
      end
      bus.addr = lo_a[i] + 5'd1;
      #200;
      n_checks++;
      if (bus.sel !== hi_s[i] || $countones(bus.sel) != 1) begin
        n_fail++;
        $display("FAIL group_hi addr=%0d: got %h want %h", lo_a[i] + 5'd1, bus.sel, hi_s[i]);
      end
    end
  endtask

  task automatic test_timing();
    @(negedge clk);
    bus.en   = 1'b1;
    bus.addr = 5'd3;
    #200;
    bus.addr = 5'd4;
    #40;
    n_checks++;
    if (bus.sel !== 32'h0000_0008) begin
      n_fail++;
      $display("FAIL timing_early: got %h want %h", bus.sel, 32'h0000_0008);
    end
    #70;
    n_checks++;
    if (bus.sel !== 32'h0000_0010) begin
      n_fail++;
      $display("FAIL timing_settled: got %h want %h", bus.sel, 32'h0000_0010);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    bus.en   = 1'b1;
    bus.addr = 5'd10;
    @(posedge clk); #1;
    n_checks++;
    if (bus.sel_q !== 32'h0000_0400) begin
      n_fail++;
      $display("FAIL midrst_before: got %h want %h", bus.sel_q, 32'h0000_0400);
    end
    #200;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.sel_q !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_async_clear: got %h want %h", bus.sel_q, 32'h0);
    end
    n_checks++;
    if (bus.sel !== 32'h0000_0400) begin
      n_fail++;
      $display("FAIL midrst_sel_kept: got %h want %h", bus.sel, 32'h0000_0400);
    end
    #100;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.sel_q !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_hold_till_edge: got %h want %h", bus.sel_q, 32'h0);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.sel_q !== 32'h0000_0400) begin
      n_fail++;
      $display("FAIL midrst_reload: got %h want %h", bus.sel_q, 32'h0000_0400);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_sweep();
    test_disable();
    test_group_boundaries();
    test_timing();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
